// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, FSM encoding and byte-enable bases for the MEM-stage data-memory controller.
package dmem_ctrl_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int RD_WIDTH   = 5;

    localparam logic [RD_WIDTH:0] RD_NONE = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Index 0 is the hardwired zero register and RD_NONE (or above) means no destination.
    function automatic logic rd_writes(input logic [RD_WIDTH:0] rd);
        return (rd < RD_NONE) && (rd != '0);
    endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// Word-addressed req/ack data-memory bus between the MEM stage (master) and the memory (slave).
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/dmem_load_align.sv
// Moves the addressed byte/halfword of a read word down to bit 0 and sign- or zero-extends it.
module dmem_load_align
    import dmem_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_lsb,
    input  logic                  i_byte,
    input  logic                  i_half,
    input  logic                  i_unsigned,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] w_shift;

    assign w_shift = i_rdata >> {i_lsb, 3'b000};

    always_comb begin
        o_data = i_rdata;
        if (i_byte) begin
            o_data = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
        end else if (i_half) begin
            o_data = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage controller: issues aligned loads/stores on the req/ack bus, stalls EX while busy,
// and hands ALU or aligned load results to writeback as a one-cycle pulse.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  ex_valid,
    output logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] alu_result_mem,
    input  logic [ADDR_WIDTH-1:0] mem_addr_mem,
    input  logic [RD_WIDTH:0]     rd_mem,
    input  logic                  load_mem,
    input  logic                  store_mem,
    input  logic                  mem_H_mem,
    input  logic                  mem_B_mem,
    input  logic                  mem_U_mem,
    input  logic [DATA_WIDTH-1:0] store_data_mem,
    dmem_ctrl_if.master           dmem,
    output logic                  wb_valid,
    output logic [RD_WIDTH:0]     wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  mem_misalign
);
    state_t r_state, w_state_next;

    logic                  w_mem_op, w_is_half, w_is_word, w_misaligned;
    logic                  w_issue, w_ack_take, w_alu_wb, w_load_wb, w_mis_next;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata, w_load_data;

    logic                  r_req, r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata, r_load_data;
    logic [1:0]            r_lsb;
    logic                  r_byte, r_half, r_unsigned, r_load;
    logic [RD_WIDTH:0]     r_rd;
    logic                  r_wb_valid, r_misalign;
    logic [RD_WIDTH:0]     r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;

    // Byte size wins over halfword when both flags are set.
    assign w_mem_op     = ex_valid & (load_mem | store_mem);
    assign w_is_half    = mem_H_mem & ~mem_B_mem;
    assign w_is_word    = ~mem_H_mem & ~mem_B_mem;
    assign w_misaligned = (w_is_half & mem_addr_mem[0]) | (w_is_word & (|mem_addr_mem[1:0]));

    always_comb begin
        w_be    = BE_WORD;
        w_wdata = store_data_mem;
        if (mem_B_mem) begin
            w_be    = BE_BYTE << mem_addr_mem[1:0];
            w_wdata = {4{store_data_mem[7:0]}};
        end else if (mem_H_mem) begin
            w_be    = BE_HALF << mem_addr_mem[1:0];
            w_wdata = {2{store_data_mem[15:0]}};
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_ready    = 1'b1;
        w_issue      = 1'b0;
        w_ack_take   = 1'b0;
        w_alu_wb     = 1'b0;
        w_load_wb    = 1'b0;
        w_mis_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        w_mis_next = 1'b1;
                    end else begin
                        mem_ready    = 1'b0;
                        w_issue      = 1'b1;
                        w_state_next = ST_BUSY;
                    end
                end else if (ex_valid) begin
                    w_alu_wb = 1'b1;
                end
            end
            ST_BUSY: begin
                mem_ready = 1'b0;
                if (dmem.dmem_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            // Inputs still show the completed op here; it is retired, never re-issued.
            ST_DONE: begin
                w_load_wb    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    dmem_load_align u_load_align (
        .i_rdata    (dmem.dmem_rdata),
        .i_lsb      (r_lsb),
        .i_byte     (r_byte),
        .i_half     (r_half),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
            r_lsb       <= '0;
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_unsigned  <= 1'b0;
            r_load      <= 1'b0;
            r_rd        <= RD_NONE;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= RD_NONE;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= w_mis_next;
            r_wb_valid <= 1'b0;
            if (w_issue) begin
                r_req      <= 1'b1;
                r_we       <= store_mem;
                r_addr     <= {mem_addr_mem[ADDR_WIDTH-1:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_lsb      <= mem_addr_mem[1:0];
                r_byte     <= mem_B_mem;
                r_half     <= w_is_half;
                r_unsigned <= mem_U_mem;
                r_load     <= load_mem;
                r_rd       <= rd_mem;
            end
            if (w_ack_take) begin
                r_req       <= 1'b0;
                r_load_data <= w_load_data;
            end
            if (w_alu_wb && rd_writes(rd_mem)) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= rd_mem;
                r_wb_data  <= alu_result_mem;
            end
            if (w_load_wb && r_load && rd_writes(r_rd)) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_data  <= r_load_data;
            end
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign wb_valid        = r_wb_valid;
    assign wb_rd           = r_wb_rd;
    assign wb_data         = r_wb_data;
    assign mem_misalign    = r_misalign;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, random ops against a byte-lane reference model,
// and a reset asserted while a bus access is outstanding.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        ex_valid = 1'b0, load_mem = 1'b0, store_mem = 1'b0;
    logic        mem_H_mem = 1'b0, mem_B_mem = 1'b0, mem_U_mem = 1'b0;
    logic [31:0] alu_result_mem = '0, mem_addr_mem = '0, store_data_mem = '0;
    logic [5:0]  rd_mem = '0;
    logic        mem_ready, wb_valid, mem_misalign;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 cpu_clk = ~cpu_clk;

    dmem_ctrl_if bus();

    dmem_ctrl dut (
        .cpu_clk        (cpu_clk),
        .cpu_rstn       (cpu_rstn),
        .ex_valid       (ex_valid),
        .mem_ready      (mem_ready),
        .alu_result_mem (alu_result_mem),
        .mem_addr_mem   (mem_addr_mem),
        .rd_mem         (rd_mem),
        .load_mem       (load_mem),
        .store_mem      (store_mem),
        .mem_H_mem      (mem_H_mem),
        .mem_B_mem      (mem_B_mem),
        .mem_U_mem      (mem_U_mem),
        .store_data_mem (store_data_mem),
        .dmem           (bus),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_misalign   (mem_misalign)
    );

    typedef struct {
        logic        ex, ld, st, h, b, u;
        logic [5:0]  rd;
        logic [31:0] addr, alu, sdata, rdata;
        int          wt;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_low;
        logic        exp_wb;
        logic [5:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int txn      = 0;

    // Memory responder: acks after cfg_wait cycles and logs what was seen on the bus.
    int          cfg_wait = 0;
    logic [31:0] cfg_rdata = '0;
    int          acc_count = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic        acc_we = 1'b0;
    logic [3:0]  acc_be = '0;
    bit          stable_err = 1'b0;

    initial begin
        int          cnt;
        logic [31:0] s_addr, s_wdata;
        logic        s_we;
        logic [3:0]  s_be;
        cnt = 0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0; s_be = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge cpu_clk);
            if (bus.dmem_req && !bus.dmem_ack) begin
                if (cnt == 0) begin
                    s_addr = bus.dmem_addr; s_wdata = bus.dmem_wdata;
                    s_we = bus.dmem_we; s_be = bus.dmem_be;
                end else if (s_addr !== bus.dmem_addr || s_wdata !== bus.dmem_wdata ||
                             s_we !== bus.dmem_we || s_be !== bus.dmem_be) begin
                    stable_err = 1'b1;
                end
                if (cnt >= cfg_wait) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = cfg_rdata;
                    acc_count++;
                    acc_addr = s_addr; acc_wdata = s_wdata; acc_we = s_we; acc_be = s_be;
                    cnt = 0;
                end else begin
                    cnt++;
                    bus.dmem_rdata = $urandom;
                end
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
                cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ex, ld, st, h, b, u, input logic [5:0] rd,
                                input logic [31:0] addr, alu, sdata, rdata, input int wt);
        vec_t v;
        v.ex = ex; v.ld = ld; v.st = st; v.h = h; v.b = b; v.u = u; v.rd = rd;
        v.addr = addr; v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.wt = wt;
        v.exp_req = 0; v.exp_we = 0; v.exp_addr = '0; v.exp_be = '0; v.exp_wdata = '0;
        v.exp_low = 0; v.exp_wb = 0; v.exp_rd = '0; v.exp_data = '0; v.exp_mis = 0;
        return v;
    endfunction

    function automatic vec_t xp(input vec_t v, input logic req, we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata, input int low,
                                input logic wb, input logic [5:0] rd, input logic [31:0] data,
                                input logic mis);
        vec_t r = v;
        r.exp_req = req; r.exp_we = we; r.exp_addr = addr; r.exp_be = be; r.exp_wdata = wdata;
        r.exp_low = low; r.exp_wb = wb; r.exp_rd = rd; r.exp_data = data; r.exp_mis = mis;
        return r;
    endfunction

    // Reference model: access size in bytes, lane arithmetic, and numeric sign extension.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          size, off;
        logic [31:0] sh;
        logic        rd_ok;
        r = mk(v.ex, v.ld, v.st, v.h, v.b, v.u, v.rd, v.addr, v.alu, v.sdata, v.rdata, v.wt);
        rd_ok = (v.rd >= 1) && (v.rd <= 31);
        if (!v.ex) return r;
        if (v.ld || v.st) begin
            size = v.b ? 1 : (v.h ? 2 : 4);
            off  = int'(v.addr % 4);
            if (off % size != 0) begin
                r.exp_mis = 1;
                return r;
            end
            r.exp_req  = 1;
            r.exp_we   = v.st;
            r.exp_addr = v.addr - 32'(off);
            r.exp_low  = v.wt + 2;
            for (int i = 0; i < 4; i++) begin
                r.exp_be[i] = (i >= off) && (i < off + size);
                r.exp_wdata[8*i +: 8] = v.sdata[8*(i % size) +: 8];
            end
            if (v.ld && rd_ok) begin
                r.exp_wb = 1;
                r.exp_rd = v.rd;
                sh = v.rdata >> (8 * off);
                if (size == 4) begin
                    r.exp_data = v.rdata;
                end else if (size == 2) begin
                    r.exp_data = 32'(sh[15:0]);
                    if (!v.u && sh[15]) r.exp_data = r.exp_data - 32'h10000;
                end else begin
                    r.exp_data = 32'(sh[7:0]);
                    if (!v.u && sh[7]) r.exp_data = r.exp_data - 32'h100;
                end
            end
        end else if (rd_ok) begin
            r.exp_wb   = 1;
            r.exp_rd   = v.rd;
            r.exp_data = v.alu;
        end
        return r;
    endfunction

    vec_t  pend;
    bit    pend_valid = 1'b0;
    string pend_name  = "";

    task automatic check_prev();
        if (pend_valid) begin
            chk({pend_name, " wb_valid"}, 32'(wb_valid), 32'(pend.exp_wb));
            if (pend.exp_wb) begin
                chk({pend_name, " wb_rd"}, 32'(wb_rd), 32'(pend.exp_rd));
                chk({pend_name, " wb_data"}, wb_data, pend.exp_data);
            end
            chk({pend_name, " misalign"}, 32'(mem_misalign), 32'(pend.exp_mis));
        end
    endtask

    // Called just after a rising edge; holds the op until the stage accepts it.
    task automatic apply(input vec_t v, input string name);
        int low, start_acc;
        bit first, extra;
        ex_valid = v.ex; load_mem = v.ld; store_mem = v.st;
        mem_H_mem = v.h; mem_B_mem = v.b; mem_U_mem = v.u; rd_mem = v.rd;
        mem_addr_mem = v.addr; alu_result_mem = v.alu; store_data_mem = v.sdata;
        cfg_wait = v.wt; cfg_rdata = v.rdata;
        start_acc = acc_count; stable_err = 1'b0;
        low = 0; first = 1'b1; extra = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (first) begin
                check_prev();
                first = 1'b0;
            end else if (wb_valid || mem_misalign) begin
                extra = 1'b1;
            end
            if (mem_ready) break;
            low++;
            if (low > 100) begin
                chk({name, " ready timeout"}, 32'(low), 32'(v.exp_low));
                break;
            end
        end
        @(posedge cpu_clk); #1;
        chk({name, " ready_low"}, 32'(low), 32'(v.exp_low));
        chk({name, " accesses"}, 32'(acc_count - start_acc), 32'(v.exp_req));
        chk({name, " stray pulse"}, 32'(extra), 32'd0);
        if (v.exp_req) begin
            chk({name, " dmem_addr"}, acc_addr, v.exp_addr);
            chk({name, " dmem_we"}, 32'(acc_we), 32'(v.exp_we));
            chk({name, " dmem_be"}, 32'(acc_be), 32'(v.exp_be));
            chk({name, " bus stable"}, 32'(stable_err), 32'd0);
            if (v.exp_we) chk({name, " dmem_wdata"}, acc_wdata, v.exp_wdata);
        end
        $display("txn %0d %s ev=%0d ld=%0d st=%0d h=%0d b=%0d addr=%h rd=%0d ready_low=%0d acc=%0d",
                 txn, name, v.ex, v.ld, v.st, v.h, v.b, v.addr, v.rd, low, acc_count - start_acc);
        txn++;
        pend = v; pend_name = name; pend_valid = 1'b1;
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, " mem_ready"}, 32'(mem_ready), 32'd1);
        chk({name, " dmem_req"}, 32'(bus.dmem_req), 32'd0);
        chk({name, " dmem_we"}, 32'(bus.dmem_we), 32'd0);
        chk({name, " dmem_addr"}, bus.dmem_addr, 32'd0);
        chk({name, " dmem_be"}, 32'(bus.dmem_be), 32'd0);
        chk({name, " dmem_wdata"}, bus.dmem_wdata, 32'd0);
        chk({name, " wb_valid"}, 32'(wb_valid), 32'd0);
        chk({name, " wb_rd"}, 32'(wb_rd), 32'd32);
        chk({name, " wb_data"}, wb_data, 32'd0);
        chk({name, " misalign"}, 32'(mem_misalign), 32'd0);
    endtask

    vec_t tbl[20];
    vec_t idle;

    initial begin
        vec_t v;
        int   kind;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = xp(mk(1,1,0,0,0,0, 5, 'h100, 0, 0, 'hDEADBEEF, 3), 1,0,'h100,'hF,0, 5, 1, 5,'hDEADBEEF,0);
        tbl[1]  = xp(mk(1,1,0,0,1,0, 7, 'h103, 0, 0, 'h80123456, 0), 1,0,'h100,'h8,0, 2, 1, 7,'hFFFFFF80,0);
        tbl[2]  = xp(mk(1,1,0,0,1,1, 7, 'h103, 0, 0, 'h80123456, 0), 1,0,'h100,'h8,0, 2, 1, 7,'h00000080,0);
        tbl[3]  = xp(mk(1,0,1,1,0,0, 9, 'h202, 0, 'h1234ABCD, 0, 1), 1,1,'h200,'hC,'hABCDABCD, 3, 0, 0, 0, 0);
        tbl[4]  = xp(mk(1,1,0,1,0,0, 4, 'h101, 0, 0, 0, 0),          0,0,0,0,0, 0, 0, 0, 0, 1);
        tbl[5]  = xp(mk(1,0,0,0,0,0, 3, 0, 7, 0, 0, 0),              0,0,0,0,0, 0, 1, 3, 7, 0);
        tbl[6]  = xp(mk(1,1,0,0,0,0,10, 'h204, 0, 0, 'h11223344, 0), 1,0,'h204,'hF,0, 2, 1,10,'h11223344,0);
        tbl[7]  = xp(mk(1,0,0,0,0,0,32, 0, 5, 0, 0, 0),              0,0,0,0,0, 0, 0, 0, 0, 0);
        tbl[8]  = xp(mk(0,1,0,0,0,0, 6, 'h100, 9, 0, 0, 0),          0,0,0,0,0, 0, 0, 0, 0, 0);
        tbl[9]  = xp(mk(1,1,0,1,0,0,11, 'h302, 0, 0, 'h8001BEEF, 0), 1,0,'h300,'hC,0, 2, 1,11,'hFFFF8001,0);
        tbl[10] = xp(mk(1,1,0,1,0,1,12, 'h300, 0, 0, 'h1234F00D, 2), 1,0,'h300,'h3,0, 4, 1,12,'h0000F00D,0);
        tbl[11] = xp(mk(1,1,0,1,1,0,13, 'h101, 0, 0, 'h0000AB00, 0), 1,0,'h100,'h2,0, 2, 1,13,'hFFFFFFAB,0);
        tbl[12] = xp(mk(1,0,1,0,0,0, 1, 'h10, 0, 'hCAFEF00D, 0, 0),  1,1,'h10,'hF,'hCAFEF00D, 2, 0, 0, 0, 0);
        tbl[13] = xp(mk(1,1,0,0,0,0, 2, 'h102, 0, 0, 0, 0),          0,0,0,0,0, 0, 0, 0, 0, 1);
        tbl[14] = xp(mk(1,0,1,0,1,0, 0, 'h3, 0, 'h00000055, 0, 0),   1,1,'h0,'h8,'h55555555, 2, 0, 0, 0, 0);
        tbl[15] = xp(mk(1,0,0,0,0,0, 0, 0, 'h99, 0, 0, 0),           0,0,0,0,0, 0, 0, 0, 0, 0);
        tbl[16] = xp(mk(1,1,0,0,0,1,14, 'h8, 0, 0, 'h80000000, 1),   1,0,'h8,'hF,0, 3, 1,14,'h80000000,0);
        tbl[17] = xp(mk(1,1,0,0,0,0, 0, 'hC, 0, 0, 'h12345678, 0),   1,0,'hC,'hF,0, 2, 0, 0, 0, 0);
        tbl[18] = xp(mk(1,1,0,0,1,0,33, 'h1, 0, 0, 'h0000C300, 0),   1,0,'h0,'h2,0, 2, 0, 0, 0, 0);
        tbl[19] = xp(mk(1,0,0,0,0,0,31, 0, 'h12345678, 0, 0, 0),     0,0,0,0,0, 0, 1,31,'h12345678,0);

        repeat (3) @(negedge cpu_clk);
        chk_reset_state("reset");
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        @(posedge cpu_clk); #1;

        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply(idle, "idle");

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 2));
            v = mk($urandom_range(0, 9) != 0, kind == 1, kind == 2, 1'($urandom), 1'($urandom),
                   1'($urandom), 6'($urandom_range(0, 40)), $urandom, $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 3)));
            apply(model(v), $sformatf("rnd%0d", i));
        end
        apply(idle, "idle");
        pend_valid = 1'b0;

        // Reset while the access is outstanding must abandon it immediately.
        ex_valid = 1'b1; load_mem = 1'b1; store_mem = 1'b0; mem_H_mem = 1'b0; mem_B_mem = 1'b0;
        mem_U_mem = 1'b0; rd_mem = 6'd8; mem_addr_mem = 32'h40; cfg_wait = 30;
        @(negedge cpu_clk);
        @(posedge cpu_clk); #1;
        chk("busy dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("busy mem_ready", 32'(mem_ready), 32'd0);
        #2;
        cpu_rstn = 1'b0;
        ex_valid = 1'b0; load_mem = 1'b0;
        #1;
        chk_reset_state("busy reset");
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        @(posedge cpu_clk); #1;
        $display("txn %0d busy_reset rd=8 addr=00000040", txn);
        txn++;

        apply(tbl[5], "post_reset add");
        apply(tbl[6], "post_reset lw");
        apply(tbl[3], "post_reset sh");
        apply(idle, "idle");
        apply(idle, "idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- MEM-stage data-memory controller; the consumer end of the EX→MEM interface driven by the ALU stage.
- Takes the registered EX result and memory-op flags, and issues word-aligned requests with byte enables on a req/ack data-memory bus.
- Aligns and extends load data, and forwards results to the WB stage.
- Throttles the pipeline through mem_ready while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data path width (matches `DATA_WIDTH)
- ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
- RD_WIDTH, 5, register index width; rd ports are RD_WIDTH+1 bits, value 32 = no destination

Ports:
- cpu_clk  in  1  CPU clock
- cpu_rstn  in  1  CPU reset, asynchronous, active low
- ex_valid  in  1  MEM-stage inputs valid
- mem_ready  out  1  MEM stage can accept; EX/MEM registers advance only when 1
- alu_result_mem  in  32  ALU result (non-memory ops)
- mem_addr_mem  in  32  byte address for load/store
- rd_mem  in  6  destination register
- load_mem, store_mem  in  1 each  op type
- mem_H_mem, mem_B_mem, mem_U_mem  in  1 each  halfword / byte / unsigned load
- store_data_mem  in  32  store source data
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_ack  in  1  access complete; rdata valid on a read
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback valid (one-cycle pulse)
- wb_rd  out  6  writeback register
- wb_data  out  32  writeback data
- mem_misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (async, any state): FSM=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0; wb_valid=0, wb_rd=32, wb_data=0, mem_misalign=0. mem_ready=1 (combinational from IDLE).
- mem_op = ex_valid & (load_mem|store_mem). Size: word when H=B=0; B has priority if both H and B are set.
- Misaligned means H with addr[0]=1, or word with addr[1:0]≠0.
- FSM states IDLE, BUSY, DONE:
  - IDLE, mem_op aligned: mem_ready=0; register dmem_req=1, dmem_we=store_mem, dmem_addr, dmem_be, dmem_wdata; go to BUSY.
  - IDLE, mem_op misaligned: no request; mem_misalign=1 next cycle; no wb; mem_ready=1; stay IDLE.
  - IDLE, ex_valid non-memory op: mem_ready=1; next cycle wb_valid=(rd_mem<32 && rd_mem≠0), wb_data=alu_result_mem.
  - BUSY: mem_ready=0; bus outputs held stable; on dmem_ack, clear dmem_req, capture the aligned load result, go to DONE. No timeout; waits indefinitely.
  - DONE: mem_ready=1; wb_valid=load_mem & rd valid (rd<32, ≠0), registered; go to IDLE. The op still presented on the inputs in DONE is not re-issued.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
- Write data: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
- Load data: sh = rdata>>(8*addr[1:0]). B: sign- or zero-extend sh[7:0] per mem_U_mem. H: sign- or zero-extend sh[15:0]. W: rdata. mem_U is ignored for word loads.
- Minimum latency, ack in the first BUSY cycle: op presented at cycle 0, req at cycle 1, DONE at cycle 2, wb_valid at cycle 3. A store produces no wb_valid.
- ex_valid=0: no request, wb_valid=0, mem_ready=1.

Decomposition:
- core_defines.vh holds DATA_WIDTH/ADDR_WIDTH/RD_WIDTH, the RD_NONE=32 constant, FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and byte-enable base constants.
- One sub-module, dmem_load_align: combinational lane shift plus sign/zero extension (rdata, addr[1:0], B, H, U → 32-bit result).

Test Plan:
- LW rd=5, addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF → one request with be=1111, addr 0x100; mem_ready low for 5 cycles; wb_valid with rd=5, data 0xDEADBEEF.
- LB signed addr 0x103, rdata 0x80xxxxxx → be=1000, wb_data 0xFFFFFF80. LBU, same address → 0x00000080.
- SH addr 0x202, data 0x1234ABCD → we=1, be=1100, wdata 0xABCDABCD, dmem_addr 0x200; no wb_valid.
- LH addr 0x101 → no dmem_req, mem_misalign single pulse, mem_ready stays 1, no wb_valid.
- Back-to-back ADD rd=3 result 7, then LW → wb_valid rd=3 data 7 the next cycle; the load is then issued without a gap. ADD with rd=32 → no wb_valid.
- Assert cpu_rstn low while in BUSY → dmem_req=0 immediately, FSM IDLE, mem_ready=1, wb_rd=32.
